// File: rtl/axi_s_ddr_model.sv
// AXI-style DDR stand-in: accepts write bursts into a 256-bit-wide on-chip memory
// and replays read bursts from it with a fixed read latency.
module axi_s_ddr_model #(
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned DQ_WIDTH        = 32,
  parameter int unsigned MEM_AW          = 10,
  parameter int unsigned RD_LATENCY      = 2
) (
  input  logic                       M_AXI_ACLK,
  input  logic                       M_AXI_ARESETN,
  input  logic [3:0]                 M_AXI_AWID,
  input  logic [CTRL_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  input  logic [3:0]                 M_AXI_AWLEN,
  input  logic                       M_AXI_AWUSER,
  input  logic                       M_AXI_AWVALID,
  output logic                       M_AXI_AWREADY,
  input  logic [DQ_WIDTH*8-1:0]      M_AXI_WDATA,
  input  logic [DQ_WIDTH-1:0]        M_AXI_WSTRB,
  output logic                       M_AXI_WREADY,
  output logic                       M_AXI_WLAST,
  output logic [3:0]                 M_AXI_WUSER,
  input  logic [3:0]                 M_AXI_ARID,
  input  logic                       M_AXI_ARUSER,
  input  logic [CTRL_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  input  logic [3:0]                 M_AXI_ARLEN,
  input  logic                       M_AXI_ARVALID,
  output logic                       M_AXI_ARREADY,
  output logic [3:0]                 M_AXI_RID,
  output logic [DQ_WIDTH*8-1:0]      M_AXI_RDATA,
  output logic                       M_AXI_RVALID,
  output logic                       M_AXI_RLAST,
  output logic [15:0]                wr_burst_cnt,
  output logic [15:0]                rd_burst_cnt
);

  localparam int unsigned DW        = DQ_WIDTH * 8;
  localparam int unsigned WAIT_W    = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned WAIT_INIT = (RD_LATENCY > 2) ? RD_LATENCY - 2 : 0;

  typedef enum logic [2:0] {IDLE, WR_ACK, WR_DATA, RD_ACK, RD_WAIT, RD_DATA} state_t;

  state_t              state_q, state_d;
  logic [3:0]          len_q, len_d, beat_q, beat_d, rid_q, rid_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [MEM_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                awready_q, awready_d, wready_q, wready_d, wlast_q, wlast_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [15:0]         wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [DW-1:0]       rdata_q;
  logic                rd_load_c;
  logic [MEM_AW-1:0]   rd_addr_c;
  logic [MEM_AW-1:0]   aw_idx_c, ar_idx_c;
  logic [DW-1:0]       mem [2**MEM_AW];
  logic                unused_inputs;

  assign aw_idx_c = M_AXI_AWADDR[MEM_AW+2:3];
  assign ar_idx_c = M_AXI_ARADDR[MEM_AW+2:3];
  assign unused_inputs = ^{M_AXI_AWID, M_AXI_AWUSER, M_AXI_ARUSER,
                           M_AXI_AWADDR[CTRL_ADDR_WIDTH-1:MEM_AW+3], M_AXI_AWADDR[2:0],
                           M_AXI_ARADDR[CTRL_ADDR_WIDTH-1:MEM_AW+3], M_AXI_ARADDR[2:0]};

  // Next-state and next-output decode; outputs are registered from the *_d values
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rid_d     = rid_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    wlast_d   = 1'b0;
    arready_d = 1'b0;
    rvalid_d  = 1'b0;
    rlast_d   = 1'b0;
    rd_load_c = 1'b0;
    rd_addr_c = rd_ptr_q;
    case (state_q)
      IDLE: begin
        if (M_AXI_AWVALID) begin
          state_d   = WR_ACK;
          awready_d = 1'b1;
        end else if (M_AXI_ARVALID) begin
          state_d   = RD_ACK;
          arready_d = 1'b1;
        end
      end
      WR_ACK: begin
        state_d  = WR_DATA;
        len_d    = M_AXI_AWLEN;
        beat_d   = 4'd0;
        wr_ptr_d = aw_idx_c;
        wready_d = 1'b1;
        wlast_d  = (M_AXI_AWLEN == 4'd0);
      end
      WR_DATA: begin
        wr_ptr_d = wr_ptr_q + MEM_AW'(1);
        if (beat_q == len_q) begin
          state_d  = IDLE;
          wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
          beat_d   = beat_q + 4'd1;
          wready_d = 1'b1;
          wlast_d  = ((beat_q + 4'd1) == len_q);
        end
      end
      RD_ACK: begin
        len_d     = M_AXI_ARLEN;
        rid_d     = M_AXI_ARID;
        beat_d    = 4'd0;
        rd_addr_c = ar_idx_c;
        rd_ptr_d  = ar_idx_c;
        wait_d    = WAIT_W'(WAIT_INIT);
        if (RD_LATENCY <= 1) begin
          state_d   = RD_DATA;
          rd_load_c = 1'b1;
          rvalid_d  = 1'b1;
          rlast_d   = (M_AXI_ARLEN == 4'd0);
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wait_q == '0) begin
          state_d   = RD_DATA;
          rd_load_c = 1'b1;
          rvalid_d  = 1'b1;
          rlast_d   = (len_q == 4'd0);
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      RD_DATA: begin
        if (beat_q == len_q) begin
          state_d  = IDLE;
          rd_cnt_d = rd_cnt_q + 16'd1;
        end else begin
          beat_d    = beat_q + 4'd1;
          rd_load_c = 1'b1;
          rvalid_d  = 1'b1;
          rlast_d   = ((beat_q + 4'd1) == len_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (rd_load_c) rd_ptr_d = rd_addr_c + MEM_AW'(1);
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      wait_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rid_q     <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      wlast_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rid_q     <= rid_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      wlast_q   <= wlast_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      if (rd_load_c) rdata_q <= mem[rd_addr_c];
    end
  end

  // Storage is deliberately outside reset so contents survive a reset pulse
  always_ff @(posedge M_AXI_ACLK) begin
    if (wready_q) begin
      for (int b = 0; b < int'(DQ_WIDTH); b++) begin
        if (M_AXI_WSTRB[b]) mem[wr_ptr_q][b*8 +: 8] <= M_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  assign M_AXI_AWREADY = awready_q;
  assign M_AXI_WREADY  = wready_q;
  assign M_AXI_WLAST   = wlast_q;
  assign M_AXI_WUSER   = 4'd0;
  assign M_AXI_ARREADY = arready_q;
  assign M_AXI_RID     = rid_q;
  assign M_AXI_RDATA   = rdata_q;
  assign M_AXI_RVALID  = rvalid_q;
  assign M_AXI_RLAST   = rlast_q;
  assign wr_burst_cnt  = wr_cnt_q;
  assign rd_burst_cnt  = rd_cnt_q;

endmodule

// File: tb/tb_axi_s_ddr_model.sv
// Directed bench for axi_s_ddr_model: bursts, strobes, priority, wrap, reset abort.
module tb_axi_s_ddr_model;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   awid, awlen, arid, arlen, wuser, rid;
  logic [27:0]  awaddr, araddr;
  logic         awuser, awvalid, awready, wready, wlast;
  logic         aruser, arvalid, arready, rvalid, rlast;
  logic [255:0] wdata, rdata;
  logic [31:0]  wstrb;
  logic [15:0]  wr_cnt, rd_cnt;

  logic [255:0] wbuf [16];
  logic [255:0] rbuf [16];
  logic [255:0] exp_v;
  int           n_checks = 0;
  int           n_errors = 0;

  always #5 clk = ~clk;

  axi_s_ddr_model dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWUSER(awuser),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WREADY(wready), .M_AXI_WLAST(wlast),
    .M_AXI_WUSER(wuser),
    .M_AXI_ARID(arid), .M_AXI_ARUSER(aruser), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RVALID(rvalid), .M_AXI_RLAST(rlast),
    .wr_burst_cnt(wr_cnt), .rd_burst_cnt(rd_cnt)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 256'({awready, wready, wlast, arready, rvalid, rlast, rid, wuser}), 256'd0);
    check({tag, "_rdata"}, rdata, 256'd0);
    check({tag, "_cnt"}, 256'({wr_cnt, rd_cnt}), 256'd0);
  endtask

  // Master side of one write burst; data comes from wbuf
  task automatic axi_write(input logic [27:0] addr, input logic [3:0] len, input logic [31:0] strb);
    bit ok = 1'b0;
    awaddr = addr; awlen = len; awvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      if (awready) begin ok = 1'b1; break; end
    end
    check("aw_accept", 256'(ok), 256'd1);
    if (!ok) begin awvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("aw_pulse", 256'(awready), 256'd0);
    for (int k = 0; k <= int'(len); k++) begin
      check("wready", 256'(wready), 256'd1);
      check("wlast", 256'(wlast), 256'(k == int'(len)));
      wdata = wbuf[k]; wstrb = strb;
      @(posedge clk); #1;
    end
    check("wready_end", 256'(wready), 256'd0);
    wstrb = '0;
  endtask

  // Master side of one read burst; beats land in rbuf; abort_at >= 0 asserts reset on that beat
  task automatic axi_read(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input int abort_at);
    bit ok = 1'b0;
    int lat;
    araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      if (arready) begin ok = 1'b1; break; end
    end
    check("ar_accept", 256'(ok), 256'd1);
    if (!ok) begin arvalid = 1'b0; return; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rd_latency", 256'(lat), 256'd2);
    for (int k = 0; k <= int'(len); k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        return;
      end
      check("rvalid", 256'(rvalid), 256'd1);
      check("rlast", 256'(rlast), 256'(k == int'(len)));
      check("rid", 256'(rid), 256'(id));
      rbuf[k] = rdata;
      @(posedge clk); #1;
    end
    check("rvalid_end", 256'(rvalid), 256'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    awid = 4'd0; awaddr = '0; awlen = '0; awuser = 1'b0; awvalid = 1'b0;
    wdata = '0; wstrb = '0;
    arid = 4'd0; araddr = '0; arlen = '0; aruser = 1'b0; arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 8-beat write then read-back of the same region
    for (int k = 0; k < 8; k++) wbuf[k] = {32{8'(k)}};
    axi_write(28'h0000100, 4'd7, 32'hFFFF_FFFF);
    axi_read(28'h0000100, 4'd7, 4'd3, -1);
    for (int k = 0; k < 8; k++) begin
      exp_v = {32{8'(k)}};
      check("burst_data", rbuf[k], exp_v);
    end
    check("cnt_t1", 256'({wr_cnt, rd_cnt}), 256'({16'd1, 16'd1}));

    // Partial strobe over a single-beat burst
    wbuf[0] = '1;
    axi_write(28'h0000200, 4'd0, 32'hFFFF_FFFF);
    wbuf[0] = '0;
    axi_write(28'h0000200, 4'd0, 32'h0000_000F);
    axi_read(28'h0000200, 4'd0, 4'd5, -1);
    exp_v = {{28{8'hFF}}, 32'h0};
    check("strobe_data", rbuf[0], exp_v);
    check("cnt_t2", 256'({wr_cnt, rd_cnt}), 256'({16'd3, 16'd2}));

    // Simultaneous requests: write wins, read sees its data
    wbuf[0] = {8{32'hC0DE_0001}};
    wbuf[1] = {8{32'hC0DE_0002}};
    araddr = 28'h0000308; arlen = 4'd0; arid = 4'd6; arvalid = 1'b1;
    axi_write(28'h0000300, 4'd1, 32'hFFFF_FFFF);
    check("prio_rd_pending", 256'(rd_cnt), 256'd2);
    axi_read(28'h0000308, 4'd0, 4'd6, -1);
    exp_v = {8{32'hC0DE_0002}};
    check("prio_data", rbuf[0], exp_v);

    // Address wrap at the top of memory
    for (int k = 0; k < 4; k++) wbuf[k] = {8{32'hA000_0000 + 32'(k)}};
    axi_write(28'h0001FF0, 4'd3, 32'hFFFF_FFFF);
    axi_read(28'h0000000, 4'd0, 4'd1, -1);
    exp_v = {8{32'hA000_0002}};
    check("wrap_idx0", rbuf[0], exp_v);
    axi_read(28'h0001FF0, 4'd3, 4'd2, -1);
    for (int k = 0; k < 4; k++) begin
      exp_v = {8{32'hA000_0000 + 32'(k)}};
      check("wrap_read", rbuf[k], exp_v);
    end
    check("cnt_t4", 256'({wr_cnt, rd_cnt}), 256'({16'd5, 16'd5}));

    // Reset during the third beat of a read; memory must survive
    axi_read(28'h0000100, 4'd7, 4'd3, 2);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_abort");
    axi_read(28'h0000100, 4'd7, 4'd3, -1);
    for (int k = 0; k < 8; k++) begin
      exp_v = {32{8'(k)}};
      check("after_reset_data", rbuf[k], exp_v);
    end
    check("cnt_t5", 256'({wr_cnt, rd_cnt}), 256'({16'd0, 16'd1}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_s_ddr_model.md
Name: axi_s_ddr_model

Overview:
- Synthesizable AXI-style responder for the write/read burst interface that the audio AXI master drives toward the DDR controller.
- Stands in for the DDR controller in simulation and in DDR-less bring-up builds.
- Accepts write bursts into an on-chip 256-bit-wide memory and returns read bursts from it.
- Drives the controller-owned handshakes: AWREADY, WREADY, WLAST, ARREADY, RVALID, RLAST, RID.

Parameters:
- CTRL_ADDR_WIDTH, 28, address width of AWADDR/ARADDR.
- DQ_WIDTH, 32, data bus is DQ_WIDTH*8 bits; WSTRB is DQ_WIDTH bits.
- MEM_AW, 10, log2 of memory depth in 256-bit beats (1024 beats).
- RD_LATENCY, 2, cycles from the ARREADY pulse to the first RVALID; minimum 1.

Ports:
- M_AXI_ACLK  in  1  single clock.
- M_AXI_ARESETN  in  1  asynchronous active-low reset.
- M_AXI_AWID  in  4  write ID; ignored.
- M_AXI_AWADDR  in  CTRL_ADDR_WIDTH  burst start address.
- M_AXI_AWLEN  in  4  beats minus 1.
- M_AXI_AWUSER  in  1  ignored.
- M_AXI_AWVALID  in  1  write request.
- M_AXI_AWREADY  out  1  write address accept pulse.
- M_AXI_WDATA  in  DQ_WIDTH*8  write beat data.
- M_AXI_WSTRB  in  DQ_WIDTH  byte enables.
- M_AXI_WREADY  out  1  beat accepted this cycle.
- M_AXI_WLAST  out  1  final write beat.
- M_AXI_WUSER  out  4  constant 0.
- M_AXI_ARID  in  4  read ID.
- M_AXI_ARUSER  in  1  ignored.
- M_AXI_ARADDR  in  CTRL_ADDR_WIDTH  read start address.
- M_AXI_ARLEN  in  4  beats minus 1.
- M_AXI_ARVALID  in  1  read request.
- M_AXI_ARREADY  out  1  read address accept pulse.
- M_AXI_RID  out  4  ID of the read in flight.
- M_AXI_RDATA  out  DQ_WIDTH*8  read beat data.
- M_AXI_RVALID  out  1  read beat valid.
- M_AXI_RLAST  out  1  final read beat.
- wr_burst_cnt  out  16  completed write bursts, wrapping.
- rd_burst_cnt  out  16  completed read bursts, wrapping.

Behaviour:
- Reset: all outputs 0 and state IDLE. Memory contents are retained. Asserting reset mid-burst aborts the burst immediately; no partial WLAST or RLAST follows.
- Addressing: addresses are in 32-bit word units and one beat is 8 words. Beat index = ADDR[MEM_AW+2:3]. ADDR[2:0] is ignored. The index increments by 1 per beat and wraps modulo 2^MEM_AW.
- FSM states: IDLE, WR_ACK, WR_DATA, RD_ACK, RD_WAIT, RD_DATA.
- IDLE:
  - AWVALID=1 -> WR_ACK. Write has priority when AWVALID and ARVALID are both high.
  - Otherwise ARVALID=1 -> RD_ACK.
- WR_ACK: AWREADY=1 for exactly one cycle. Latch AWADDR and AWLEN. Next state WR_DATA.
- WR_DATA:
  - WREADY=1 for AWLEN+1 consecutive cycles.
  - Each WREADY cycle the slave samples WDATA/WSTRB and writes memory byte b when WSTRB[b]=1; bytes with WSTRB[b]=0 are unchanged.
  - WLAST=1 together with WREADY on the final beat only. AWLEN=0 gives a single cycle with WREADY and WLAST both high.
  - After the final beat: wr_burst_cnt+1, go to IDLE.
- RD_ACK: ARREADY=1 for one cycle. Latch ARADDR, ARLEN, ARID. Next state RD_WAIT.
- RD_WAIT: wait so that the first RVALID occurs exactly RD_LATENCY cycles after the ARREADY cycle.
- RD_DATA:
  - RVALID=1 for ARLEN+1 consecutive cycles; there is no RREADY and the master always accepts.
  - RDATA is registered memory output. RID holds the latched ARID while RVALID=1.
  - RLAST=1 on the final beat only.
  - After the final beat: rd_burst_cnt+1, go to IDLE.
- Gaps: at least one IDLE cycle separates bursts. Requests arriving outside IDLE wait; AWVALID/ARVALID are held by the master until accepted.
- Hazards: writes complete fully before any read is accepted, so read-after-write to the same beat always returns the new data.
- Idle outputs: RDATA and RID are don't-care when RVALID=0 but hold their last value (no X after reset).

Test Plan:
- Write AWADDR=0x0000100, AWLEN=7, WDATA=beat index replicated, WSTRB all 1s; then read the same address with ARLEN=7, ARID=3 -> AWREADY pulse; 8 WREADY cycles with WLAST on the 8th; first RVALID 2 cycles after ARREADY; RDATA beats 0..7; RID=3; RLAST on the 8th beat; wr_burst_cnt=1, rd_burst_cnt=1.
- Partial strobe: write beat 0xFF..FF, then write 0 with WSTRB=0x0000000F, then read -> upper 28 bytes are 0xFF, low 4 bytes are 0x00.
- AWVALID and ARVALID asserted in the same cycle to different addresses -> write burst completes first; read accepted afterwards returns post-write data.
- Wrap: AWADDR index 1022 (ADDR=0x1FF0), AWLEN=3 -> beats land at indices 1022, 1023, 0, 1; readback of index 0 returns beat 2.
- AWLEN=0 and ARLEN=0 single beats -> WREADY and WLAST high together for one cycle; RVALID and RLAST high together for one cycle.
- Reset asserted during beat 3 of an 8-beat read -> all outputs 0 in the same cycle; after release, a new read of the same address returns previously written data.
